mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter BOOT_HOLD, default 2, cycles between loader completion and CPU start.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rom_mapped  input  1  loader reports code image written (level).
REQ-006 SHALL have port first_instruction  input  32  loader-computed entry PC, valid when rom_mapped=1.
REQ-007 SHALL have port mem_access  output  1  grants memory port to loader.
REQ-008 SHALL have ports ldr_addr/ldr_data_in/ldr_write_en  input  ADDR_W/8/1  loader write request, sampled only while mem_access=1.
REQ-009 SHALL have ports cpu_req/cpu_we/cpu_addr/cpu_wdata  input  1/1/ADDR_W/8  CPU request.
REQ-010 SHALL have ports dbg_req/dbg_we/dbg_addr/dbg_wdata  input  1/1/ADDR_W/8  debug request.
REQ-011 SHALL have ports cpu_gnt, dbg_gnt  output  1 each  request accepted this cycle.
REQ-012 SHALL have ports cpu_rvalid, dbg_rvalid  output  1 each  read data valid on rdata.
REQ-013 SHALL have port rdata  output  8  read data, shared by both requesters.
REQ-014 SHALL have ports mem_en/mem_we/mem_addr/mem_wdata  output  1/1/ADDR_W/8  to byte-wide synchronous RAM.
REQ-015 SHALL have port mem_rdata  input  8  RAM read data, one cycle after mem_en with mem_we=0.
REQ-016 SHALL have ports cpu_start (1-cycle pulse) and start_pc (32)  output  CPU release and entry PC.

Function
REQ-017 SHALL implement states BOOT, HOLD, START, RUN.
REQ-018 BOOT: mem_access=1; mem_en=ldr_write_en, mem_we=ldr_write_en, mem_addr=ldr_addr, mem_wdata=ldr_data_in (combinational pass-through); cpu_gnt=dbg_gnt=0.
REQ-019 BOOT -> HOLD on the cycle rom_mapped=1 is sampled; start_pc latches first_instruction in that same cycle.
REQ-020 HOLD: mem_access=0, mem_en=0; down-counter loaded with BOOT_HOLD counts to 0; at 0 -> START.
REQ-021 BOOT_HOLD=0 SHALL go BOOT -> START directly.
REQ-022 START: cpu_start=1 for exactly one cycle, no grants; -> RUN.
REQ-023 RUN: mem_access=0 permanently; loader inputs ignored; rom_mapped deassertion ignored.
REQ-024 RUN arbitration: at most one grant per cycle; a single requester is granted the same cycle (combinational gnt).
REQ-025 Simultaneous cpu_req and dbg_req: round-robin; a 1-bit last-winner register (reset = dbg) means the CPU wins the first conflict; the loser is granted next cycle if still requesting.
REQ-026 Granted request SHALL drive mem_en=1, mem_we=req_we, mem_addr and mem_wdata from the winner in the grant cycle.
REQ-027 Granted read: matching rvalid=1 exactly one cycle after gnt, rdata=mem_rdata; back-to-back reads SHALL produce back-to-back rvalid, tagged to the correct requester.
REQ-028 Granted write: no rvalid.
REQ-029 When no grant: mem_en=0, mem_we=0; mem_addr/mem_wdata hold their last value.
REQ-030 Requesters SHALL hold their request signals until granted; the arbiter SHALL NOT queue requests.

Reset
REQ-031 rst=1 at any clock: state=BOOT, hold counter=0, start_pc=0, last-winner=dbg, rvalid pipeline cleared.
REQ-032 During and after reset: cpu_start=0, cpu_gnt=dbg_gnt=0, cpu_rvalid=dbg_rvalid=0, rdata=0, mem_en=0, mem_we=0.
REQ-033 mem_access=1 from the first cycle after reset.
REQ-034 Reset mid-RUN SHALL discard any pending rvalid; no rvalid may appear in the cycle after reset.

Verification
REQ-035 Boot handoff: loader writes 0x41 to 0x30, then rom_mapped=1 with first_instruction=0x32 -> RAM[0x30]=0x41; mem_access drops next cycle; cpu_start pulses 3 cycles after the rom_mapped sample (BOOT_HOLD=2); start_pc=0x32.
REQ-036 Lockout: cpu_req=1 throughout BOOT and HOLD -> cpu_gnt=0 until the cycle after cpu_start.
REQ-037 Conflict: in RUN, cpu and dbg both read constant requests -> grants alternate cpu, dbg, cpu, dbg; each rvalid follows its gnt by one cycle.
REQ-038 Read after write: cpu writes 0xA5 to 0x100, then reads 0x100 -> cpu_rvalid=1 with rdata=0xA5 one cycle after the read grant.
REQ-039 Reset mid-read: assert rst in the cycle after a dbg read grant -> dbg_rvalid stays 0; mem_access=1 after reset.
REQ-040 BOOT_HOLD=0 build: rom_mapped=1 -> cpu_start is asserted on the next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Boot-time memory port arbiter: the loader owns the RAM port until the code image is mapped,
// then the CPU is released and CPU/debug requests share the port under round-robin arbitration.
module mem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int BOOT_HOLD = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rom_mapped,
   input  logic [31:0]       first_instruction,
   output logic              mem_access,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [7:0]        ldr_data_in,
   input  logic              ldr_write_en,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [7:0]        dbg_wdata,
   output logic              cpu_gnt,
   output logic              dbg_gnt,
   output logic              cpu_rvalid,
   output logic              dbg_rvalid,
   output logic [7:0]        rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              cpu_start,
   output logic [31:0]       start_pc
);

   localparam int CNT_W = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD + 1) : 1;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_START = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       start_pc_q, start_pc_d;
   logic              last_dbg_q, last_dbg_d;
   logic              cpu_rv_q, dbg_rv_q;
   logic [ADDR_W-1:0] addr_hold_q;
   logic [7:0]        wdata_hold_q;
   logic              run_s, cpu_win_s, dbg_win_s;

   // Boot sequencing: next state, hold countdown and entry-PC capture
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      start_pc_d = start_pc_q;
      case (state_q)
         ST_BOOT: begin
            if (rom_mapped) begin
               start_pc_d = first_instruction;
               if (BOOT_HOLD == 0) begin
                  state_d = ST_START;
               end else begin
                  state_d = ST_HOLD;
                  cnt_d   = CNT_W'(BOOT_HOLD);
               end
            end else begin
               state_d = ST_BOOT;
            end
         end
         ST_HOLD: begin
            // The transition fires as the counter reaches zero, so HOLD lasts BOOT_HOLD cycles
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_START;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = ST_HOLD;
            end
         end
         ST_START: state_d = ST_RUN;
         ST_RUN:   state_d = ST_RUN;
         default:  state_d = ST_BOOT;
      endcase
   end

   // Round-robin arbitration; the last-winner bit breaks ties in favour of the other side
   always_comb begin
      run_s      = (state_q == ST_RUN) && !rst;
      cpu_win_s  = run_s && cpu_req && (!dbg_req || last_dbg_q);
      dbg_win_s  = run_s && dbg_req && (!cpu_req || !last_dbg_q);
      if (cpu_win_s) begin
         last_dbg_d = 1'b0;
      end else if (dbg_win_s) begin
         last_dbg_d = 1'b1;
      end else begin
         last_dbg_d = last_dbg_q;
      end
   end

   // RAM port mux: loader pass-through in BOOT, granted requester in RUN, otherwise idle with held address/data
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = addr_hold_q;
      mem_wdata = wdata_hold_q;
      if ((state_q == ST_BOOT) && !rst) begin
         mem_en    = ldr_write_en;
         mem_we    = ldr_write_en;
         mem_addr  = ldr_addr;
         mem_wdata = ldr_data_in;
      end else if (cpu_win_s) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dbg_win_s) begin
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end else begin
         mem_en    = 1'b0;
      end
   end

   // State, counters, tie-break memory, read-tag pipeline and held RAM address/data
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_BOOT;
         cnt_q        <= {CNT_W{1'b0}};
         start_pc_q   <= 32'd0;
         last_dbg_q   <= 1'b1;
         cpu_rv_q     <= 1'b0;
         dbg_rv_q     <= 1'b0;
         addr_hold_q  <= {ADDR_W{1'b0}};
         wdata_hold_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         start_pc_q   <= start_pc_d;
         last_dbg_q   <= last_dbg_d;
         cpu_rv_q     <= cpu_win_s && !cpu_we;
         dbg_rv_q     <= dbg_win_s && !dbg_we;
         addr_hold_q  <= mem_addr;
         wdata_hold_q <= mem_wdata;
      end
   end

   assign mem_access = (state_q == ST_BOOT);
   assign cpu_gnt    = cpu_win_s;
   assign dbg_gnt    = dbg_win_s;
   assign cpu_rvalid = cpu_rv_q && !rst;
   assign dbg_rvalid = dbg_rv_q && !rst;
   assign rdata      = (cpu_rvalid || dbg_rvalid) ? mem_rdata : 8'd0;
   assign cpu_start  = (state_q == ST_START) && !rst;
   assign start_pc   = start_pc_q;

endmodule
